lsu_mem_arb: RTL and testbench
==============================

LSU_MEM_ARB -- requirements
Module: lsu_mem_arb

Interface
REQ-001 Parameter NREQ, default 4: number of LSU requesters (2..8).
REQ-002 Parameter AW, default 16: word address width.
REQ-003 Parameter DW, default 32: data width.
REQ-004 clk  input  1  clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 req_valid  input  NREQ  per-requester access request.
REQ-007 req_we  input  NREQ  1 = write, 0 = read.
REQ-008 req_addr  input  NREQ*AW  requester i in bits [i*AW +: AW].
REQ-009 req_wdata  input  NREQ*DW  requester i in bits [i*DW +: DW].
REQ-010 req_ready  output  NREQ  one-hot grant; transfer occurs when req_valid[i] & req_ready[i].
REQ-011 flush  input  1  stop new grants and drain any outstanding read.
REQ-012 idle  output  1  high in IDLE with no outstanding read.
REQ-013 mem_en, mem_we  output  1 each  shared single-port memory strobe and write enable.
REQ-014 mem_addr  output  AW; mem_wdata  output  DW; mem_rdata  input  DW, valid exactly 1 cycle after a read strobe.
REQ-015 resp_valid  output  NREQ  one-hot read-return strobe.
REQ-016 resp_data  output  DW  read data for the requester flagged by resp_valid.

Function
REQ-017 States: IDLE (no request pending), SERVE (granting), DRAIN (flush active, no grants).
REQ-018 IDLE->SERVE when any req_valid is high and flush is low; SERVE->IDLE when no req_valid is high; IDLE/SERVE->DRAIN when flush is high; DRAIN->IDLE when flush is low and no read is outstanding.
REQ-019 At most one requester is granted per cycle; the grant is combinational from req_valid and the priority pointer, and req_ready is all zero in DRAIN or when flush is high.
REQ-020 Round-robin: after a transfer by requester g, the pointer becomes (g+1) mod NREQ; the search starts at the pointer and wraps from NREQ-1 to 0.
REQ-021 A transfer drives mem_en=1, mem_we=req_we[g], mem_addr, mem_wdata from requester g in the same cycle.
REQ-022 A read transfer produces resp_valid[g]=1 and resp_data=mem_rdata exactly 1 cycle later; writes produce no response.
REQ-023 Back-to-back reads from different requesters every cycle are supported, at full throughput.
REQ-024 With a single requester continuously valid, it is granted every cycle.
REQ-025 A requester deasserting req_valid without a transfer causes no memory access.
REQ-026 flush asserted in the same cycle as a read transfer: the grant is suppressed, and any read granted in the previous cycle still returns its response.
REQ-027 mem_wdata is 0 and mem_addr holds its last value when mem_en is 0.

Reset
REQ-028 On rst: state IDLE, pointer 0, no read outstanding, req_ready=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, resp_valid=0, resp_data=0, idle=1.
REQ-029 rst during an outstanding read discards that read's response; resp_valid stays 0 in the cycle after reset.

Configuration
REQ-030 Macro LSU_ARB_STATS_EN defined: adds output stall_cnt (NREQ*16), where counter i increments by 1, saturating at 16'hFFFF, in every cycle that req_valid[i] & ~req_ready[i]; it is cleared by rst.
REQ-031 LSU_ARB_STATS_EN undefined: no stall_cnt port and no counter logic; all other behaviour is identical.

Verification
REQ-032 Bench must drive all 4 requesters to read continuously from 0x10,0x20,0x30,0x40 -> grants 0,1,2,3,0 on consecutive cycles, and resp_valid one cycle later carries the matching mem_rdata.
REQ-033 Bench must drive requester 2 alone to write 0xDEADBEEF to 0x0005 and then read 0x0005 -> mem_we 1 then 0, then resp_valid=4'b0100 with 0xDEADBEEF.
REQ-034 Bench must assert flush the cycle after a read by requester 1 while all requesters are valid -> one response for requester 1, req_ready=0 while flush is high, then idle=1.
REQ-035 Bench must assert rst the cycle after a read grant -> resp_valid stays 0, all outputs take their reset values, and the pointer restarts at requester 0.
REQ-036 With LSU_ARB_STATS_EN defined, bench must hold requesters 0 and 1 valid for 10 cycles -> stall_cnt[0]=5 and stall_cnt[1]=5.

Source files
------------

// File: rtl/lsu_mem_arb.sv
// Round-robin arbiter letting NREQ load/store requesters share one single-port memory.
// Optional stall counters per requester are built when LSU_ARB_STATS_EN is defined.
module lsu_mem_arb #(
  parameter int NREQ = 4,
  parameter int AW   = 16,
  parameter int DW   = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ-1:0]      req_we,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*DW-1:0]   req_wdata,
  output logic [NREQ-1:0]      req_ready,
  input  logic                 flush,
  output logic                 idle,
  output logic                 mem_en,
  output logic                 mem_we,
  output logic [AW-1:0]        mem_addr,
  output logic [DW-1:0]        mem_wdata,
  input  logic [DW-1:0]        mem_rdata,
  output logic [NREQ-1:0]      resp_valid,
  output logic [DW-1:0]        resp_data,
`ifdef LSU_ARB_STATS_EN
  output logic [NREQ*16-1:0]   stall_cnt,
`endif
  output logic [1:0]           fsm_state
);

  // Handshake: requester i transfers in the cycle where req_valid[i] & req_ready[i];
  // a granted read returns on resp_valid[i]/resp_data exactly one cycle later.

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   gidx;
  logic [PW:0]     cand;
  logic            found;
  logic            grant_en;
  logic            xfer;
  logic            rd_pend;
  logic [NREQ-1:0] rd_gnt;
  logic [AW-1:0]   last_addr;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_wdata;
  logic            sel_we;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (flush) state_nxt = DRAIN;
               else if (|req_valid) state_nxt = SERVE;
      SERVE:   if (flush) state_nxt = DRAIN;
               else if (!(|req_valid)) state_nxt = IDLE;
      DRAIN:   if (!flush && !rd_pend) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Grant search starts at ptr and wraps; reset and flush block grants combinationally.
  assign grant_en = !rst && !flush && (state != DRAIN);

  always_comb begin
    req_ready = '0;
    gidx      = '0;
    cand      = '0;
    found     = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_we    = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, ptr} + (PW+1)'(k);
      if (cand >= (PW+1)'(NREQ)) cand = cand - (PW+1)'(NREQ);
      if (grant_en && !found && req_valid[cand[PW-1:0]]) begin
        req_ready[cand[PW-1:0]] = 1'b1;
        gidx  = cand[PW-1:0];
        found = 1'b1;
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (req_ready[i]) begin
        sel_addr  = req_addr[i*AW +: AW];
        sel_wdata = req_wdata[i*DW +: DW];
        sel_we    = req_we[i];
      end
    end
  end

  assign xfer       = |req_ready;
  assign mem_en     = xfer;
  assign mem_we     = xfer & sel_we;
  assign mem_addr   = xfer ? sel_addr : last_addr;
  assign mem_wdata  = sel_wdata;
  // A reset landing on the return cycle discards the pending response.
  assign resp_valid = (rd_pend && !rst) ? rd_gnt : '0;
  assign resp_data  = (rd_pend && !rst) ? mem_rdata : '0;
  assign idle       = (state == IDLE) && !rd_pend;
  assign fsm_state  = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr       <= '0;
      rd_pend   <= 1'b0;
      rd_gnt    <= '0;
      last_addr <= '0;
    end else begin
      rd_pend <= xfer & ~sel_we;
      rd_gnt  <= req_ready;
      if (xfer) begin
        ptr       <= (gidx == PW'(NREQ-1)) ? '0 : gidx + PW'(1);
        last_addr <= sel_addr;
      end
    end
  end

`ifdef LSU_ARB_STATS_EN
  logic [15:0] cnt_q [NREQ];

  always_ff @(posedge clk) begin
    for (int i = 0; i < NREQ; i++) begin
      if (rst) cnt_q[i] <= '0;
      else if (req_valid[i] && !req_ready[i] && cnt_q[i] != 16'hFFFF)
        cnt_q[i] <= cnt_q[i] + 16'd1;
    end
  end

  for (genvar g = 0; g < NREQ; g++) begin : g_stall
    assign stall_cnt[g*16 +: 16] = cnt_q[g];
  end
`endif

endmodule

// File: tb/tb_lsu_mem_arb.sv
// Bench for lsu_mem_arb: directed scenarios plus random traffic, checked by a
// scoreboard against a behavioural arbitration/memory model.
module tb_lsu_mem_arb;
  localparam int NREQ = 4;
  localparam int AW   = 16;
  localparam int DW   = 32;
  localparam int GW   = 55;
  localparam int RW   = 68;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_we;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata;
  logic [NREQ-1:0]   req_ready;
  logic              flush;
  logic              idle;
  logic              mem_en;
  logic              mem_we;
  logic [AW-1:0]     mem_addr;
  logic [DW-1:0]     mem_wdata;
  logic [DW-1:0]     mem_rdata;
  logic [NREQ-1:0]   resp_valid;
  logic [DW-1:0]     resp_data;
  logic [1:0]        fsm_state;
`ifdef LSU_ARB_STATS_EN
  logic [NREQ*16-1:0] stall_cnt;
`endif

  lsu_mem_arb #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .flush(flush), .idle(idle),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .resp_valid(resp_valid), .resp_data(resp_data),
`ifdef LSU_ARB_STATS_EN
    .stall_cnt(stall_cnt),
`endif
    .fsm_state(fsm_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  // ---------------- memory environment ----------------
  logic [DW-1:0] env_mem [logic [AW-1:0]];

  function automatic logic [DW-1:0] dflt(input logic [AW-1:0] a);
    return {~a, a} ^ 32'h5A5A_0000;
  endfunction

  always @(posedge clk) begin
    if (mem_en === 1'b1) begin
      if (mem_we) env_mem[mem_addr] = mem_wdata;
      else mem_rdata = env_mem.exists(mem_addr) ? env_mem[mem_addr] : dflt(mem_addr);
    end else begin
      mem_rdata = $urandom;
    end
  end

  // ---------------- reference model ----------------
  logic [DW-1:0] ref_mem [logic [AW-1:0]];
  int            m_ptr = 0;
  bit            m_pend = 0, m_drain = 0, m_busy = 0;
  logic [AW-1:0] m_last = '0;
  int            m_stall [NREQ];

  logic [GW-1:0] gnt_q[$];
  logic [RW-1:0] exp_q[$];
  bit            chk_en = 0;
  int            n_vec = 0;
  int            n_err = 0;

  function automatic logic [DW-1:0] rdval(input logic [AW-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic [NREQ-1:0] v, input logic [NREQ-1:0] w,
                       input logic [NREQ*AW-1:0] a, input logic [NREQ*DW-1:0] d,
                       input logic f, input logic r);
    int g;
    logic [NREQ-1:0] rdy;
    logic en, we, idl;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    req_valid = v; req_we = w; req_addr = a; req_wdata = d; flush = f; rst = r;
    g = -1;
    if (!r && !f && !m_drain)
      for (int k = 0; k < NREQ; k++)
        if (g < 0 && v[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
    rdy = '0;
    if (g >= 0) rdy[g] = 1'b1;
    en  = (g >= 0);
    we  = en && w[g];
    ea  = en ? a[g*AW +: AW] : m_last;
    ed  = en ? d[g*DW +: DW] : '0;
    idl = !m_drain && !m_busy && !m_pend;
    if (r) exp_q.delete();
    if (chk_en) gnt_q.push_back({idl, rdy, en, we, ea, ed});
    if (en && !we) exp_q.push_back({32'(cyc + 1), rdy, rdval(ea)});
    if (en && we) ref_mem[ea] = ed;
    for (int i = 0; i < NREQ; i++) begin
      if (r) m_stall[i] = 0;
      else if (v[i] && !rdy[i] && m_stall[i] < 65535) m_stall[i]++;
    end
    if (r) begin
      m_ptr = 0; m_pend = 0; m_drain = 0; m_busy = 0; m_last = '0;
    end else begin
      if (m_drain) begin
        if (!f && !m_pend) m_drain = 0;
      end else if (f) begin
        m_drain = 1; m_busy = 0;
      end else begin
        m_busy = |v;
      end
      m_pend = en && !we;
      if (en) begin
        m_ptr  = (g + 1) % NREQ;
        m_last = ea;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic quiet(input int n);
    for (int i = 0; i < n; i++) drive('0, '0, '0, '0, 1'b0, 1'b0);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [GW-1:0] e;
    logic [RW-1:0] x;
    if (chk_en) begin
      if (gnt_q.size() == 0) begin
        chk("gnt_q_underflow", 64'(gnt_q.size()), 64'd1);
      end else begin
        e = gnt_q.pop_front();
        chk("req_ready", 64'(req_ready), 64'(e[53:50]));
        chk("mem_en",    64'(mem_en),    64'(e[49]));
        chk("mem_we",    64'(mem_we),    64'(e[48]));
        chk("mem_addr",  64'(mem_addr),  64'(e[47:32]));
        chk("mem_wdata", 64'(mem_wdata), 64'(e[31:0]));
        chk("idle",      64'(idle),      64'(e[54]));
      end
      if (resp_valid !== '0) begin
        if (exp_q.size() == 0) begin
          chk("resp_unexpected", 64'(resp_valid), 64'd0);
        end else begin
          x = exp_q.pop_front();
          chk("resp_cycle", 64'(cyc), 64'(x[67:36]));
          chk("resp_valid", 64'(resp_valid), 64'(x[35:32]));
          chk("resp_data",  64'(resp_data),  64'(x[31:0]));
        end
      end else begin
        chk("resp_data_zero", 64'(resp_data), 64'd0);
        if (exp_q.size() != 0 && int'(exp_q[0][67:36]) <= cyc) begin
          x = exp_q.pop_front();
          chk("resp_missing", 64'(resp_valid), 64'(x[35:32]));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [NREQ*AW-1:0] ra;
  logic [NREQ*DW-1:0] rd;

  initial begin
    for (int i = 0; i < NREQ; i++) m_stall[i] = 0;
    rst = 1'b1; flush = 1'b0; req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    @(posedge clk); #1;
    chk_en = 1;
    drive('0, '0, '0, '0, 1'b0, 1'b1);
    quiet(2);

    // four readers, consecutive round-robin grants 0,1,2,3,0
    for (int i = 0; i < 5; i++)
      drive(4'hF, 4'h0, {16'h0040, 16'h0030, 16'h0020, 16'h0010}, '0, 1'b0, 1'b0);
    quiet(2);

    // requester 2 alone: write then read back
    drive('0, '0, '0, '0, 1'b0, 1'b1);
    drive(4'b0100, 4'b0100, {16'h0, 16'h0005, 16'h0, 16'h0},
          {32'h0, 32'hDEADBEEF, 32'h0, 32'h0}, 1'b0, 1'b0);
    drive(4'b0100, 4'b0000, {16'h0, 16'h0005, 16'h0, 16'h0}, '0, 1'b0, 1'b0);
    quiet(2);

    // flush right after requester 1's read, all requesters valid
    drive('0, '0, '0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 2; i++)
      drive(4'hF, 4'h0, {16'h0104, 16'h0103, 16'h0102, 16'h0101}, '0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      drive(4'hF, 4'h0, {16'h0104, 16'h0103, 16'h0102, 16'h0101}, '0, 1'b1, 1'b0);
    quiet(3);

    // reset in the cycle after a read grant
    for (int i = 0; i < 3; i++)
      drive(4'hF, 4'h0, {16'h0204, 16'h0203, 16'h0202, 16'h0201}, '0, 1'b0, 1'b0);
    drive(4'hF, 4'h0, {16'h0204, 16'h0203, 16'h0202, 16'h0201}, '0, 1'b0, 1'b1);
    for (int i = 0; i < 2; i++)
      drive(4'hF, 4'h0, {16'h0204, 16'h0203, 16'h0202, 16'h0201}, '0, 1'b0, 1'b0);
    quiet(2);

    // randomized traffic on a small address window
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        ra[i*AW +: AW] = 16'($urandom_range(0, 15));
        rd[i*DW +: DW] = $urandom;
      end
      drive(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), ra, rd,
            1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 63) == 0));
    end
    quiet(3);

`ifdef LSU_ARB_STATS_EN
    drive('0, '0, '0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++)
      drive(4'b0011, 4'b0000, {16'h0, 16'h0, 16'h0302, 16'h0301}, '0, 1'b0, 1'b0);
    quiet(1);
    chk("stall_cnt0", 64'(stall_cnt[15:0]),  64'd5);
    chk("stall_cnt1", 64'(stall_cnt[31:16]), 64'd5);
    for (int i = 0; i < NREQ; i++)
      chk("stall_cnt_model", 64'(stall_cnt[i*16 +: 16]), 64'(m_stall[i]));
`endif

    quiet(4);
    chk("resp_outstanding", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
